// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier operand sequencer (mul_operand_seq).
package mul_pkg;

  localparam int MUL_WIDTH          = 16;
  localparam int MUL_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    FEED_B = 2'd2,
    HOLD   = 2'd3
  } mul_state_e;

  typedef struct packed {
    logic [MUL_WIDTH-1:0] a;
    logic [MUL_WIDTH-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mul_seq_fifo.sv
// Two-entry synchronous FIFO; flags come straight from the registered count,
// so a pop never frees a slot for a push in the same cycle.
module mul_seq_fifo
  import mul_pkg::*;
#(
  parameter int DW = 2 * MUL_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_r [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rd_data   = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mul_operand_seq.sv
// Operand sequencer in front of the sequential multiplier: buffers operand pairs,
// drives A then B on the shared bus, captures the product. Optional watchdog: MUL_SEQ_TIMEOUT_EN.
module mul_operand_seq
  import mul_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int TIMEOUT_CYCLES = MUL_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] mul_data_in,
  output logic             mul_start,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  mul_state_e           state_r;
  mul_state_e           state_nx_s;
  logic                 pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [2*WIDTH-1:0]   head_s;
  logic [WIDTH-1:0]     cur_b_r;
  logic                 timeout_s;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign op_ready = !fifo_full_s;

  mul_seq_fifo #(.DW(2 * WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (op_valid),
    .pop     (pop_s),
    .wr_data ({op_a, op_b}),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and FIFO pop decode; HOLD may pop directly into the next operation.
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_nx_s = LOAD_A;
          pop_s      = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD_A: state_nx_s = FEED_B;
      FEED_B: begin
        if (mul_done || timeout_s) begin
          state_nx_s = HOLD;
        end else begin
          state_nx_s = FEED_B;
        end
      end
      HOLD: begin
        if (res_ready) begin
          if (!fifo_empty_s) begin
            state_nx_s = LOAD_A;
            pop_s      = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; the bus keeps its last value outside LOAD_A/FEED_B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start   <= 1'b0;
      mul_data_in <= '0;
      cur_b_r     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      busy        <= 1'b0;
    end else begin
      mul_start <= (state_nx_s == LOAD_A);
      res_valid <= (state_nx_s == HOLD);
      busy      <= (state_nx_s != IDLE);
      if (pop_s) begin
        mul_data_in <= head_s[2*WIDTH-1:WIDTH];
        cur_b_r     <= head_s[WIDTH-1:0];
      end else if (state_r == LOAD_A) begin
        mul_data_in <= cur_b_r;
      end
      if ((state_r == FEED_B) && mul_done) begin
        res_data <= mul_data_out;
      end else if (timeout_s) begin
        res_data <= '0;
      end
    end
  end

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_r;

  // The last FEED_B cycle without mul_done aborts the operation.
  assign timeout_s = (state_r == FEED_B) && !mul_done &&
                     (to_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
      res_err  <= 1'b0;
    end else begin
      if (state_r == LOAD_A) begin
        to_cnt_r <= '0;
      end else if (state_r == FEED_B) begin
        to_cnt_r <= to_cnt_r + CNT_W'(1);
      end
      if ((state_r == FEED_B) && mul_done) begin
        res_err <= 1'b0;
      end else if (timeout_s) begin
        res_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mul_operand_seq.sv
// Randomised self-checking bench for mul_operand_seq with a transaction-level reference model
// and a stand-in sequential multiplier.
module tb_mul_operand_seq;
  import mul_pkg::*;

  localparam int W  = 16;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] mul_data_in;
  logic         mul_start;
  logic         mul_done;
  logic [W-1:0] mul_data_out;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pairs accepted but not started, the pair in flight, the held result.
  op_pair_t     fifo_q[$];
  op_pair_t     push_log[$];
  logic [W-1:0] res_log[$];
  op_pair_t     cur;
  int           phase;
  int           feed_cnt;
  bit           held;
  logic [W-1:0] held_data;
  bit           held_err;

  // Stand-in multiplier.
  bit           mul_auto;
  int           mul_lat;
  int           mm_cnt;
  logic [W-1:0] mm_a;

  mul_operand_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .mul_data_in  (mul_data_in),
    .mul_start    (mul_start),
    .mul_done     (mul_done),
    .mul_data_out (mul_data_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_err      (res_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] prod16(input op_pair_t p);
    logic [31:0] full_p;
    full_p = 32'(p.a) * 32'(p.b);
    return full_p[W-1:0];
  endfunction

  task automatic model_clear();
    fifo_q.delete();
    phase    = 0;
    feed_cnt = 0;
    held     = 1'b0;
    held_err = 1'b0;
  endtask

  // One clock: advance the model on what was presented before the edge, then compare.
  task automatic cycle();
    bit           push_s, hs_s, done_s, start_exp;
    op_pair_t     pp;
    logic [W-1:0] mdo_s, rd_s, exp_bus;
    logic [31:0]  p;
    push_s = op_valid && op_ready && rst_n;
    hs_s   = res_valid && res_ready;
    done_s = mul_done;
    mdo_s  = mul_data_out;
    rd_s   = res_data;
    pp.a   = op_a;
    pp.b   = op_b;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_clear();
    end else begin
      start_exp = (((phase == 0) && !held) || hs_s) && (fifo_q.size() > 0);
      if (hs_s) begin
        held = 1'b0;
        res_log.push_back(rd_s);
      end
      if (phase == 2) begin
        if (done_s) begin
          held = 1'b1; held_data = mdo_s; held_err = 1'b0; phase = 0;
        end
`ifdef MUL_SEQ_TIMEOUT_EN
        else begin
          feed_cnt++;
          if (feed_cnt == TO) begin
            held = 1'b1; held_data = '0; held_err = 1'b1; phase = 0;
          end
        end
`endif
      end else if (phase == 1) begin
        phase    = 2;
        feed_cnt = 0;
      end
      if (start_exp) begin
        cur   = fifo_q.pop_front();
        phase = 1;
      end
      if (push_s) begin
        fifo_q.push_back(pp);
        push_log.push_back(pp);
      end
    end
    n_checks++;
    if (mul_start !== (phase == 1)) $display("FAIL mul_start t=%0t got %b want %b", $time, mul_start, (phase == 1));
    else n_pass++;
    if (phase != 0) begin
      exp_bus = (phase == 1) ? cur.a : cur.b;
      n_checks++;
      if (mul_data_in !== exp_bus) $display("FAIL mul_bus t=%0t got %h want %h", $time, mul_data_in, exp_bus);
      else n_pass++;
    end
    n_checks++;
    if (res_valid !== held) $display("FAIL res_valid t=%0t got %b want %b", $time, res_valid, held);
    else n_pass++;
    if (held) begin
      n_checks++;
      if (res_data !== held_data || res_err !== held_err)
        $display("FAIL res_data t=%0t got %h/%b want %h/%b", $time, res_data, res_err, held_data, held_err);
      else n_pass++;
    end
    n_checks++;
    if (op_ready !== (fifo_q.size() < 2)) $display("FAIL op_ready t=%0t got %b want %b", $time, op_ready, (fifo_q.size() < 2));
    else n_pass++;
    n_checks++;
    if (busy !== ((phase != 0) || held)) $display("FAIL busy t=%0t got %b want %b", $time, busy, ((phase != 0) || held));
    else n_pass++;
    if (mul_auto) begin
      mul_done     = 1'b0;
      mul_data_out = 16'($urandom);
      if (mul_start) begin
        mm_a   = mul_data_in;
        mm_cnt = mul_lat;
      end else if (mm_cnt > 0) begin
        mm_cnt--;
        if (mm_cnt == 0) begin
          p            = 32'(mm_a) * 32'(mul_data_in);
          mul_done     = 1'b1;
          mul_data_out = p[W-1:0];
        end
      end
    end
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    acc      = 1'b0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = op_ready;
      cycle();
    end
    op_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL push_timeout got op_ready=0 want accept of %h,%h within 200 cycles", a, b);
    end
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !res_valid; i++) cycle();
    if (!res_valid) begin
      n_checks++;
      $display("FAIL wait_valid got res_valid=0 want 1 within %0d cycles", max);
    end
  endtask

  task automatic wait_results(input int n, input int max);
    for (int i = 0; i < max && res_log.size() < n; i++) cycle();
    if (res_log.size() < n) begin
      n_checks++;
      $display("FAIL wait_results got %0d want %0d results", res_log.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [36:0] rst_exp;
    rst_exp = {1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    cycle();
    n_checks++;
    if ({op_ready, mul_start, mul_data_in, res_valid, res_data, res_err, busy} !== rst_exp)
      $display("FAIL reset_values got %h want %h", {op_ready, mul_start, mul_data_in, res_valid, res_data, res_err, busy}, rst_exp);
    else n_pass++;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    mul_lat = 8; res_ready = 1'b0; res_log.delete();
    push_pair(16'h0004, 16'h0003);
    cycle();
    n_checks++;
    if (mul_start !== 1'b1 || mul_data_in !== 16'h0004) $display("FAIL single_load_a got %b/%h want 1/0004", mul_start, mul_data_in);
    else n_pass++;
    cycle();
    n_checks++;
    if (mul_start !== 1'b0 || mul_data_in !== 16'h0003) $display("FAIL single_feed_b got %b/%h want 0/0003", mul_start, mul_data_in);
    else n_pass++;
    wait_valid(50);
    n_checks++;
    if (res_data !== 16'h000C || res_err !== 1'b0) $display("FAIL single_result got %h/%b want 000c/0", res_data, res_err);
    else n_pass++;
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_release got %b/%b want 0/0", res_valid, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_r [4];
    op_pair_t     p4;
    mul_lat = 4; res_ready = 1'b1; res_log.delete();
    p4.a = 16'($urandom); p4.b = 16'($urandom);
    exp_r[0] = 16'h000A; exp_r[1] = 16'h003F; exp_r[2] = 16'hFFFE; exp_r[3] = prod16(p4);
    push_pair(16'h0002, 16'h0005);
    push_pair(16'h0007, 16'h0009);
    push_pair(16'hFFFF, 16'h0002);
    op_valid = 1'b1; op_a = p4.a; op_b = p4.b;
    n_checks++;
    if (op_ready !== 1'b0) $display("FAIL b2b_full_block got op_ready=%b want 0", op_ready);
    else n_pass++;
    push_pair(p4.a, p4.b);
    wait_results(4, 200);
    for (int i = 0; i < 4; i++) begin
      if (i < res_log.size()) begin
        n_checks++;
        if (res_log[i] !== exp_r[i]) $display("FAIL b2b_result%0d got %h want %h", i, res_log[i], exp_r[i]);
        else n_pass++;
      end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    op_pair_t q1, q2;
    mul_lat = 3; res_ready = 1'b0; res_log.delete();
    q1.a = 16'($urandom); q1.b = 16'($urandom);
    q2.a = 16'($urandom); q2.b = 16'($urandom);
    push_pair(16'h0011, 16'h0010);
    wait_valid(50);
    push_pair(q1.a, q1.b);
    push_pair(q2.a, q2.b);
    for (int i = 0; i < 20; i++) cycle();
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0110 || mul_start !== 1'b0 || op_ready !== 1'b0)
      $display("FAIL bp_hold got v=%b d=%h s=%b r=%b want 1/0110/0/0", res_valid, res_data, mul_start, op_ready);
    else n_pass++;
    res_ready = 1'b1;
    wait_results(3, 100);
    if (res_log.size() == 3) begin
      n_checks++;
      if (res_log[1] !== prod16(q1) || res_log[2] !== prod16(q2))
        $display("FAIL bp_drain got %h,%h want %h,%h", res_log[1], res_log[2], prod16(q1), prod16(q2));
      else n_pass++;
    end
    res_ready = 1'b0;
  endtask

  task automatic test_stray_done();
    res_ready = 1'b0;
    mul_done = 1'b1; mul_data_out = 16'hBEEF;
    cycle();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0) $display("FAIL stray_idle got v=%b b=%b want 0/0", res_valid, busy);
    else n_pass++;
    mul_lat = 6;
    push_pair(16'h0005, 16'h0006);
    cycle();
    mul_done = 1'b1; mul_data_out = 16'hDEAD;
    cycle();
    n_checks++;
    if (res_valid !== 1'b0 || mul_data_in !== 16'h0006) $display("FAIL stray_load_a got v=%b bus=%h want 0/0006", res_valid, mul_data_in);
    else n_pass++;
    wait_valid(50);
    mul_done = 1'b1; mul_data_out = 16'h1234;
    cycle();
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h001E) $display("FAIL stray_hold got v=%b d=%h want 1/001e", res_valid, res_data);
    else n_pass++;
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [36:0] rst_exp;
    rst_exp = {1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    mul_lat = 30; res_ready = 1'b0;
    push_pair(16'h0003, 16'h0003);
    push_pair(16'h0004, 16'h0004);
    cycle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({op_ready, mul_start, mul_data_in, res_valid, res_data, res_err, busy} !== rst_exp)
      $display("FAIL reset_mid got %h want %h", {op_ready, mul_start, mul_data_in, res_valid, res_data, res_err, busy}, rst_exp);
    else n_pass++;
    model_clear();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) cycle();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1 || mul_start !== 1'b0)
      $display("FAIL reset_late_done got v=%b b=%b r=%b s=%b want 0/0/1/0", res_valid, busy, op_ready, mul_start);
    else n_pass++;
  endtask

`ifdef MUL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    mul_auto = 1'b0; mul_done = 1'b0; res_ready = 1'b0;
    push_pair(16'h1234, 16'h5678);
    wait_valid(100);
    n_checks++;
    if (res_err !== 1'b1 || res_data !== 16'h0000) $display("FAIL timeout_result got %b/%h want 1/0000", res_err, res_data);
    else n_pass++;
    mul_done = 1'b1; mul_data_out = 16'hAAAA;
    cycle();
    mul_done = 1'b0;
    n_checks++;
    if (res_err !== 1'b1 || res_data !== 16'h0000 || res_valid !== 1'b1) $display("FAIL timeout_stray got %b/%h want 1/0000", res_err, res_data);
    else n_pass++;
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    mul_auto = 1'b1;
  endtask
`endif

  task automatic test_random();
    res_log.delete();
    push_log.delete();
    for (int i = 0; i < 600; i++) begin
      op_valid  = 1'($urandom_range(0, 1));
      op_a      = 16'($urandom);
      op_b      = 16'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      mul_lat   = int'($urandom_range(2, 6));
      cycle();
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 300 && res_log.size() < push_log.size(); i++) cycle();
    n_checks++;
    if (res_log.size() !== push_log.size()) $display("FAIL rand_count got %0d want %0d", res_log.size(), push_log.size());
    else n_pass++;
    for (int i = 0; i < res_log.size() && i < push_log.size(); i++) begin
      n_checks++;
      if (res_log[i] !== prod16(push_log[i])) $display("FAIL rand_result%0d got %h want %h", i, res_log[i], prod16(push_log[i]));
      else n_pass++;
    end
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
    mul_done = 1'b0; mul_data_out = 16'h0000; res_ready = 1'b0;
    mul_auto = 1'b1; mul_lat = 8; mm_cnt = 0; mm_a = 16'h0000;
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_stray_done();
    test_reset_mid();
`ifdef MUL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500000 time units");
    $fatal(1, "simulation time limit");
  end

endmodule
